// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the word-addressed PC, fetches from instruction
// memory over req/ready, hands instructions to decode over valid/ready, applies redirects.
module fetch_sequencer #(
  parameter int unsigned            ADDR_W   = 64,
  parameter int unsigned            INST_W   = 32,
  parameter logic [ADDR_W-1:0]      RESET_PC = '0,
  parameter int unsigned            CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              br_valid,
  input  logic              branch,
  input  logic              uncond_branch,
  input  logic              z_flag,
  input  logic [ADDR_W-1:0] br_pc,
  input  logic [ADDR_W-1:0] br_offset,
  output logic [ADDR_W-1:0] pc,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_ISSUE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                pend_q, pend_d;
  logic [INST_W-1:0]   inst_q, inst_d;
  logic [ADDR_W-1:0]   inst_pc_q, inst_pc_d;
  logic [CNT_W-1:0]    retired_q, retired_d;
  logic                imem_req_q;
  logic                inst_valid_q;

  logic                take_c;
  logic [ADDR_W-1:0]   target_c;

  // Redirect resolution: CBNZ-style conditional or unconditional, target wraps.
  assign take_c   = br_valid & (uncond_branch | (branch & ~z_flag));
  assign target_c = br_pc + br_offset;

  // Next-state logic; a pending redirect marks the in-flight response as stale.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_d    = pend_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    retired_d = retired_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          if (pend_q || take_c) begin
            pend_d = 1'b0;
            if (take_c) pc_d = target_c;
          end else begin
            inst_d    = imem_rdata;
            inst_pc_d = pc_q;
            state_d   = S_ISSUE;
          end
        end else if (take_c) begin
          pc_d   = target_c;
          pend_d = 1'b1;
        end
      end
      S_ISSUE: begin
        if (take_c) begin
          pc_d    = target_c;
          state_d = S_FETCH;
        end else if (inst_ready) begin
          retired_d = retired_q + CNT_W'(1);
          pc_d      = pc_q + ADDR_W'(1);
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      pend_q       <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      retired_q    <= '0;
      imem_req_q   <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      retired_q    <= retired_d;
      imem_req_q   <= (state_d == S_FETCH);
      inst_valid_q <= (state_d == S_ISSUE);
    end
  end

  assign imem_req   = imem_req_q;
  assign imem_addr  = pc_q;
  assign pc         = pc_q;
  assign inst_valid = inst_valid_q;
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed test-plan steps plus random traffic,
// all checked against a transaction-level model of fetch/issue behaviour.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [63:0] inst_pc;
  logic        br_valid = 1'b0;
  logic        branch = 1'b0;
  logic        uncond_branch = 1'b0;
  logic        z_flag = 1'b0;
  logic [63:0] br_pc = '0;
  logic [63:0] br_offset = '0;
  logic [63:0] pc;
  logic [31:0] retired;

  // second instance with the PC parked at the top of the address space
  logic        w_rst = 1'b1, w_start = 1'b0, w_ready = 1'b0, w_iready = 1'b0;
  logic        w_zero = 1'b0;
  logic [63:0] w_zero64 = '0;
  logic [31:0] w_rdata = 32'hCAFE_0001;
  logic        w_req, w_valid;
  logic [63:0] w_addr, w_ipc, w_pc;
  logic [31:0] w_inst, w_ret;

  int total = 0;
  int bad = 0;

  // model: where the fetch stream is, and what decode should see
  bit          m_fetching, m_holding, m_pend;
  logic [63:0] m_pc, m_ipc;
  logic [31:0] m_inst, m_ret;

  always #5 clk = ~clk;

  fetch_sequencer u_dut (
    .clk(clk), .rst(rst), .start(start),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .br_valid(br_valid), .branch(branch), .uncond_branch(uncond_branch), .z_flag(z_flag),
    .br_pc(br_pc), .br_offset(br_offset), .pc(pc), .retired(retired)
  );

  fetch_sequencer #(.RESET_PC({64{1'b1}})) u_wrap (
    .clk(clk), .rst(w_rst), .start(w_start),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(w_ready), .imem_rdata(w_rdata),
    .inst_valid(w_valid), .inst_ready(w_iready), .inst(w_inst), .inst_pc(w_ipc),
    .br_valid(w_zero), .branch(w_zero), .uncond_branch(w_zero), .z_flag(w_zero),
    .br_pc(w_zero64), .br_offset(w_zero64), .pc(w_pc), .retired(w_ret)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_update();
    logic        take;
    logic [63:0] tgt;
    take = br_valid && (uncond_branch || (branch && !z_flag));
    tgt  = br_pc + br_offset;
    if (rst) begin
      m_fetching = 0; m_holding = 0; m_pend = 0;
      m_pc = '0; m_ipc = '0; m_inst = '0; m_ret = '0;
    end else if (m_holding) begin
      if (take) begin
        m_pc = tgt; m_holding = 0; m_fetching = 1;
      end else if (inst_ready) begin
        m_ret = m_ret + 1; m_pc = m_pc + 1; m_holding = 0; m_fetching = 1;
      end
    end else if (m_fetching) begin
      if (imem_ready) begin
        if (m_pend || take) begin
          m_pend = 0;
          if (take) m_pc = tgt;
        end else begin
          m_inst = imem_rdata; m_ipc = m_pc; m_fetching = 0; m_holding = 1;
        end
      end else if (take) begin
        m_pc = tgt; m_pend = 1;
      end
    end else if (start) begin
      m_fetching = 1;
    end
  endtask

  task automatic check_all();
    chk("imem_req", imem_req, m_fetching);
    chk("imem_addr", imem_addr, m_pc);
    chk("pc", pc, m_pc);
    chk("inst_valid", inst_valid, m_holding);
    chk("inst", inst, m_inst);
    chk("inst_pc", inst_pc, m_ipc);
    chk("retired", retired, m_ret);
  endtask

  task automatic tick();
    model_update();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic quiet();
    rst = 0; start = 0; imem_ready = 0; imem_rdata = $urandom; inst_ready = 0;
    br_valid = 0; branch = 0; uncond_branch = 0; z_flag = 0; br_pc = '0; br_offset = '0;
  endtask

  task automatic fetch_accept();
    quiet(); imem_ready = 1; tick();
    quiet(); inst_ready = 1; tick();
  endtask

  initial begin
    logic [31:0] held;
    int          off;

    // reset, then idle without start
    quiet(); rst = 1; tick(); tick();
    chk("rst_req", imem_req, 1'b0);
    chk("rst_ret", retired, 32'd0);
    quiet(); tick(); tick();
    chk("idle_req", imem_req, 1'b0);
    quiet(); start = 1; tick();
    chk("start_req", imem_req, 1'b1);
    chk("start_addr", imem_addr, 64'd0);

    // sequential stream 0,1,2,...
    for (int k = 0; k < 3; k++) begin
      quiet(); imem_ready = 1; tick();
      chk("seq_ipc", inst_pc, 64'(k));
      quiet(); inst_ready = 1; tick();
      chk("seq_addr", imem_addr, 64'(k + 1));
    end
    chk("seq_ret3", retired, 32'd3);

    // decode stall at inst_pc=5
    fetch_accept(); fetch_accept();
    quiet(); imem_ready = 1; tick();
    held = inst;
    for (int k = 0; k < 4; k++) begin
      quiet(); tick();
      chk("stall_valid", inst_valid, 1'b1);
      chk("stall_inst", inst, held);
      chk("stall_ipc", inst_pc, 64'd5);
      chk("stall_ret", retired, 32'd5);
    end
    quiet(); inst_ready = 1; tick();
    chk("stall_next", imem_addr, 64'd6);

    // taken CBNZ in ISSUE beats inst_ready
    fetch_accept(); fetch_accept();
    quiet(); imem_ready = 1; tick();
    chk("br_ipc", inst_pc, 64'd8);
    quiet(); inst_ready = 1; br_valid = 1; branch = 1; z_flag = 0;
    br_pc = 64'd7; br_offset = 64'(-3); tick();
    chk("br_flush", inst_valid, 1'b0);
    chk("br_ret", retired, 32'd8);
    chk("br_addr", imem_addr, 64'd4);

    // not-taken CBNZ (zero set) lets the accept through
    for (int k = 0; k < 4; k++) fetch_accept();
    quiet(); imem_ready = 1; tick();
    quiet(); inst_ready = 1; br_valid = 1; branch = 1; z_flag = 1;
    br_pc = 64'd7; br_offset = 64'(-3); tick();
    chk("nt_addr", imem_addr, 64'd9);
    chk("nt_ret", retired, 32'd13);

    // redirect while the memory is still busy: stale data dropped
    fetch_accept();
    chk("pend_start", imem_addr, 64'd10);
    quiet(); br_valid = 1; uncond_branch = 1; br_pc = 64'd15; br_offset = 64'd5; tick();
    chk("pend_addr", imem_addr, 64'd20);
    quiet(); tick();
    quiet(); imem_ready = 1; tick();
    chk("pend_drop", inst_valid, 1'b0);
    chk("pend_req", imem_req, 1'b1);
    quiet(); imem_ready = 1; tick();
    chk("pend_ipc", inst_pc, 64'd20);

    // reset during ISSUE, then during FETCH
    quiet(); rst = 1; tick();
    chk("rsti_valid", inst_valid, 1'b0);
    chk("rsti_pc", pc, 64'd0);
    chk("rsti_ret", retired, 32'd0);
    for (int k = 0; k < 3; k++) begin
      quiet(); tick();
      chk("rsti_idle", imem_req, 1'b0);
    end
    quiet(); start = 1; tick();
    fetch_accept();
    chk("rstf_pre", imem_req, 1'b1);
    quiet(); rst = 1; tick();
    chk("rstf_req", imem_req, 1'b0);
    chk("rstf_pc", pc, 64'd0);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      quiet();
      rst           = ($urandom_range(0, 99) == 0);
      start         = ($urandom_range(0, 3) == 0);
      imem_ready    = $urandom_range(0, 1) != 0;
      inst_ready    = $urandom_range(0, 1) != 0;
      br_valid      = ($urandom_range(0, 5) == 0);
      branch        = $urandom_range(0, 1) != 0;
      uncond_branch = ($urandom_range(0, 3) == 0);
      z_flag        = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 3) == 0) begin
        br_pc     = {$urandom, $urandom};
        br_offset = {$urandom, $urandom};
      end else begin
        off       = int'($urandom_range(0, 40));
        br_pc     = 64'($urandom_range(0, 50));
        br_offset = 64'(off - 20);
      end
      tick();
    end

    // PC wrap from all-ones to zero
    quiet();
    w_rst = 1; @(posedge clk); #1;
    chk("wrap_rst_pc", w_pc, {64{1'b1}});
    chk("wrap_rst_req", w_req, 1'b0);
    w_rst = 0; w_start = 1; @(posedge clk); #1;
    chk("wrap_req", w_req, 1'b1);
    chk("wrap_addr0", w_addr, {64{1'b1}});
    w_start = 0; w_ready = 1; @(posedge clk); #1;
    chk("wrap_valid", w_valid, 1'b1);
    chk("wrap_ipc", w_ipc, {64{1'b1}});
    chk("wrap_inst", w_inst, 64'h0000_0000_CAFE_0001);
    w_ready = 0; w_iready = 1; @(posedge clk); #1;
    chk("wrap_addr1", w_addr, 64'd0);
    chk("wrap_ret", w_ret, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
